led_matrix_driver: RTL and testbench
====================================

Name: led_matrix_driver

Overview:
- Drives the 8x8 LED matrix under the board: the display-side counterpart to the reed-switch scanning FSM.
- Accepts a 64-bit square map (same bit order as chessLayout) through a valid/ready handshake and double-buffers it.
- Time-multiplexes the map onto the LEDs one row at a time, refreshing continuously.
- Inserts blanking between rows to suppress ghosting.

Parameters:
- DWELL_CYCLES, 16, clocks each row is lit (must be >= 1).
- BLANK_CYCLES, 2, clocks with all outputs off before each row (must be >= 1).
- CNT_W, 8, width of the internal phase counter (must hold max(DWELL_CYCLES, BLANK_CYCLES) - 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame  in  64  square map; bit 1 = LED on; row k = frame[63-8k : 56-8k], column i = bit i of that byte
- frame_valid  in  1  frame is offered
- frame_ready  out  1  pending buffer empty; transfer occurs on a clock edge with frame_valid && frame_ready
- row_en  out  8  one-hot row select, active-high; bit k = row k
- col_drv  out  8  column data for the selected row, active-high
- frame_done  out  1  one-cycle pulse during the final DRIVE cycle of row 7

Behaviour:
- Sampling and reset: all state is updated on posedge clk. While reset = 0 at an edge:
  - state becomes IDLE; both buffers and the pending flag clear.
  - row_en = 0, col_drv = 0, frame_done = 0, frame_ready = 1 (registered).
  - Any in-progress frame or transfer is abandoned, including a reset mid-DRIVE.
- Buffers: a pending register (pend, pend_full) and a display register (disp).
  - frame_ready = !pend_full.
  - A handshake loads pend <= frame and sets pend_full.
  - frame is ignored when frame_ready = 0.
- States: IDLE, BLANK, DRIVE. Registers: row index (3 bits, 0..7) and phase counter cnt.
- IDLE:
  - Outputs are off.
  - If pend_full: disp <= pend, clear pend_full, row <= 0, cnt <= 0, go to BLANK.
- BLANK:
  - row_en = 0, col_drv = 0.
  - When cnt == BLANK_CYCLES-1: cnt <= 0, go to DRIVE. Otherwise cnt++.
- DRIVE:
  - row_en = 1 << row; col_drv = disp byte for row.
  - When cnt == DWELL_CYCLES-1: cnt <= 0, go to BLANK.
    - If row < 7: row++.
    - If row == 7: row <= 0 (wrap). If pend_full, also disp <= pend and clear pend_full (promotion only at the frame boundary). Otherwise disp is retained and the same frame refreshes indefinitely.
- frame_done: asserted while state = DRIVE, row = 7 and cnt = DWELL_CYCLES-1.
- Outputs are registered so that they reflect the current state:
  - row_en and col_drv change only on edges.
  - col_drv is never nonzero while row_en = 0.
- Latency:
  - Acceptance edge E0 -> IDLE promotes at E1 -> row_en = 8'h01 first visible after edge E(1+BLANK_CYCLES).
  - This is 3 clocks with the defaults.
- Frame period: 8 * (BLANK_CYCLES + DWELL_CYCLES) clocks. This is 144 with the defaults and is constant regardless of handshakes.
- Boundary cases:
  - Promotion at the row-7 wrap frees pend, so frame_ready rises on the following cycle. A new frame cannot overwrite pend on the same edge, because ready was low.
  - A pending frame waiting through a frame stalls the producer; it is never dropped.
  - All-zero frame: rows are still scanned, col_drv = 0 throughout.
- No combinational path from frame or frame_valid to any output.

Test Plan:
- Reset values: hold reset = 0 for 2 clocks with frame_valid = 1 -> row_en = 0, col_drv = 0, frame_done = 0, frame_ready = 1; no transfer occurs.
- First frame latency: offer 64'hFF00_0000_0000_0000 accepted at edge E0 -> row_en = 8'h01, col_drv = 8'hFF from E3 for 16 clocks, then 2 blank clocks, then row_en = 8'h02, col_drv = 8'h00.
- Bit mapping: frame 64'h8040_2010_0804_0201 -> rows 0..7 show col_drv 80, 40, 20, 10, 08, 04, 02, 01 with row_en 01, 02, ..., 80 in order.
- Refresh and period: no further frames -> frame_done pulses exactly every 144 clocks and the pattern repeats unchanged.
- Back-pressure: offer frame A, then B, then hold C valid -> B is accepted, ready stays low, and C is accepted only on the cycle after A's row-7 wrap. Display switches A -> B exactly at a frame boundary; no torn frame.
- Reset mid-DRIVE: assert reset during row 3 -> next edge gives all outputs 0 and frame_ready = 1; after release, no LEDs light until a new frame is accepted.

Source files
------------

// File: rtl/led_matrix_driver.sv
// Row-multiplexed driver for the 8x8 board LED matrix: double-buffered frame
// intake over valid/ready, with blanking inserted before every lit row.
module led_matrix_driver #(
  parameter int DWELL_CYCLES = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] frame,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  row_en,
  output logic [7:0]  col_drv,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [2:0]       row;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [63:0]      pend;
  logic [63:0]      disp;
  logic             pend_full;

  assign cnt_inc = cnt + CNT_ONE;

  // Row k lives in the byte starting at bit 8*(7-k); for 3 bits, 7-k == ~k.
  function automatic logic [7:0] row_byte(input logic [63:0] f, input logic [2:0] r);
    return f[{~r, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      row         <= 3'd0;
      cnt         <= '0;
      pend        <= '0;
      disp        <= '0;
      pend_full   <= 1'b0;
      frame_ready <= 1'b1;
      row_en      <= 8'h00;
      col_drv     <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      // Intake and promotion never coincide: intake needs pend empty, promotion needs it full.
      if (frame_valid && frame_ready) begin
        pend        <= frame;
        pend_full   <= 1'b1;
        frame_ready <= 1'b0;
      end
      row_en     <= 8'h00;
      col_drv    <= 8'h00;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_full) begin
            disp        <= pend;
            pend_full   <= 1'b0;
            frame_ready <= 1'b1;
            row         <= 3'd0;
            cnt         <= '0;
            state       <= BLANK;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt        <= '0;
            state      <= DRIVE;
            row_en     <= 8'b1 << row;
            col_drv    <= row_byte(disp, row);
            frame_done <= (row == 3'd7) && (DWELL_LAST == '0);
          end else begin
            cnt <= cnt_inc;
          end
        end
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            state <= BLANK;
            row   <= row + 3'd1;
            // A waiting frame only replaces the display at the frame boundary.
            if (row == 3'd7 && pend_full) begin
              disp        <= pend;
              pend_full   <= 1'b0;
              frame_ready <= 1'b1;
            end
          end else begin
            cnt        <= cnt_inc;
            row_en     <= 8'b1 << row;
            col_drv    <= row_byte(disp, row);
            frame_done <= (row == 3'd7) && (cnt_inc == DWELL_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Bench for led_matrix_driver: time-based reference model of the scan pattern
// and buffer handshake, driven by directed and random frames.
module tb_led_matrix_driver;
  localparam int B = 2;
  localparam int D = 16;
  localparam int SLOT = B + D;
  localparam int T = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] frame = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [7:0]  row_en;
  logic [7:0]  col_drv;
  logic        frame_done;

  always #5 clk = ~clk;

  led_matrix_driver #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .row_en(row_en), .col_drv(col_drv), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: idle flag, buffers, and cycles elapsed since the current frame began.
  bit          m_idle = 1'b1;
  bit          m_pend_full = 1'b0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_disp = '0;
  int          m_j = 0;

  bit track_period = 1'b0;
  int last_done = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit accept;
    int s, r, w;
    logic [7:0] e_row, e_col;
    logic e_done;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_idle = 1'b1; m_pend_full = 1'b0; m_pend = '0; m_disp = '0; m_j = 0;
    end else begin
      accept = frame_valid && !m_pend_full;
      if (m_idle) begin
        if (m_pend_full) begin
          m_disp = m_pend; m_pend_full = 1'b0; m_idle = 1'b0; m_j = 0;
        end
      end else begin
        m_j = (m_j + 1) % T;
        if (m_j == 0 && m_pend_full) begin
          m_disp = m_pend; m_pend_full = 1'b0;
        end
      end
      if (accept) begin
        m_pend = frame; m_pend_full = 1'b1;
      end
    end
    #1;
    e_row = 8'h00; e_col = 8'h00; e_done = 1'b0;
    if (!m_idle) begin
      s = m_j;
      r = s / SLOT;
      w = s % SLOT;
      if (w >= B) begin
        e_row = 8'(1 << r);
        e_col = m_disp[8*(7-r) +: 8];
      end
      e_done = (r == 7) && (w == SLOT - 1);
    end
    chk("row_en", row_en, e_row);
    chk("col_drv", col_drv, e_col);
    chk("frame_done", frame_done, e_done);
    chk("frame_ready", frame_ready, !m_pend_full);
    if (track_period && frame_done === 1'b1) begin
      if (last_done >= 0) chk("period", cyc - last_done, T);
      last_done = cyc;
    end
  endtask

  task automatic offer(input logic [63:0] f);
    bit acc;
    acc = 1'b0;
    frame = f;
    frame_valid = 1'b1;
    for (int k = 0; k < 3 * T; k++) begin
      acc = frame_ready;
      step();
      if (acc) break;
    end
    chk("offer_accepted", acc, 1'b1);
    frame_valid = 1'b0;
  endtask

  initial begin
    // Reset held with a frame offered: nothing may be taken.
    reset = 1'b0;
    frame_valid = 1'b1;
    frame = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    step();
    reset = 1'b1;
    frame_valid = 1'b0;
    repeat (4) step();

    // First frame latency and steady refresh period.
    track_period = 1'b1;
    last_done = -1;
    offer(64'hFF00_0000_0000_0000);
    repeat (3 * T + 5) step();
    track_period = 1'b0;

    // Diagonal bit mapping, then an all-zero frame.
    offer(64'h8040_2010_0804_0201);
    repeat (2 * T) step();
    offer(64'h0);
    repeat (T + 20) step();

    // Back-pressure: A, B, then C held until pend frees at a frame boundary.
    offer(64'hAAAA_5555_AAAA_5555);
    offer(64'h0102_0408_1020_4080);
    offer(64'hF0F0_0F0F_F0F0_0F0F);
    repeat (3 * T) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 5000; i++) begin
      frame_valid = ($urandom_range(0, 7) == 0);
      frame = ($urandom_range(0, 5) == 0) ? 64'h0 : {$urandom, $urandom};
      reset = ($urandom_range(0, 699) != 0);
      step();
    end
    reset = 1'b1;
    frame_valid = 1'b0;

    // Reset while row 3 is lit, then confirm the matrix stays dark.
    offer({$urandom, $urandom} | 64'h0000_00FF_0000_0000);
    for (int k = 0; k < 3 * T; k++) begin
      step();
      if (row_en === 8'h08) break;
    end
    chk("reach_row3", row_en, 8'h08);
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (2 * T) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
